// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional madd/msub accumulate ops are built when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2:0]         r_op;
  logic               w_op_ok, w_accept, w_done, w_idle;
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;
  logic [2*WIDTH-1:0] w_umul, w_smul;
  logic               w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_uq, w_ur, w_mq, w_mr, w_sq, w_sr;

  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_op_ok = ~op[2];
`ifdef MDU_MADD_EN
    if (op[2:1] == 2'b11) w_op_ok = 1'b1;
`endif
  end

  assign w_accept = start && w_idle && w_op_ok;
  assign w_done   = (r_state == S_RUN) && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign-extended operands multiplied modulo 2^(2W) give the two's-complement signed product.
  assign w_umul = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_smul = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};

  assign w_a_neg  = r_a[WIDTH-1];
  assign w_b_neg  = r_b[WIDTH-1];
  assign w_b_zero = (r_b == '0);
  assign w_a_mag  = w_a_neg ? -r_a : r_a;
  assign w_b_mag  = w_b_neg ? -r_b : r_b;
  assign w_uq     = w_b_zero ? '0 : r_a / r_b;
  assign w_ur     = w_b_zero ? '0 : r_a % r_b;
  assign w_mq     = w_b_zero ? '0 : w_a_mag / w_b_mag;
  assign w_mr     = w_b_zero ? '0 : w_a_mag % w_b_mag;
  // Magnitude divide then re-sign; most-negative / -1 wraps back to most-negative.
  assign w_sq     = (w_a_neg ^ w_b_neg) ? -w_mq : w_mq;
  assign w_sr     = w_a_neg ? -w_mr : w_mr;

  always_comb begin
    {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo};
    case (r_op)
      3'b000:  {w_hi_nxt, w_lo_nxt} = w_umul;
      3'b001:  {w_hi_nxt, w_lo_nxt} = w_smul;
      3'b010:  {w_hi_nxt, w_lo_nxt} = {w_ur, w_uq};
      3'b011:  {w_hi_nxt, w_lo_nxt} = {w_sr, w_sq};
`ifdef MDU_MADD_EN
      3'b110:  {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_smul;
      3'b111:  {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_smul;
`endif
      default: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo};
    endcase
    if ((r_op[2:1] == 2'b01) && w_b_zero) begin
      w_hi_nxt = r_a;
      w_lo_nxt = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= op;
      end
      if (w_done) begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
      end else if (start && w_idle && op == 3'b100) begin
        r_hi <= A;
      end else if (start && w_idle && op == 3'b101) begin
        r_lo <= A;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expectations queued at issue, checked at completion.
module tb_mdu_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic [W-1:0] HI, LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  task automatic run_check(input string nm, input int already);
    int   n;
    exp_t e;
    n = already;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      total++;
      if (n !== int'(e.cyc)) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, n, e.cyc); end
      total++;
      if (HI !== e.hi) begin bad++; $display("FAIL %s HI got=%h exp=%h", nm, HI, e.hi); end
      total++;
      if (LO !== e.lo) begin bad++; $display("FAIL %s LO got=%h exp=%h", nm, LO, e.lo); end
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int cyc);
    sb.push_back('{hi: hi, lo: lo, cyc: 32'(cyc)});
    issue(o, a, b);
    run_check(nm, 0);
  endtask

  task automatic do_mt(input string nm, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; A = a;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b exp=0", nm, busy); end
    total++;
    if (o == 3'b100 && HI !== a) begin bad++; $display("FAIL %s HI got=%h exp=%h", nm, HI, a); end
    else if (o == 3'b101 && LO !== a) begin bad++; $display("FAIL %s LO got=%h exp=%h", nm, LO, a); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, HI, LO} !== '0) begin bad++; $display("FAIL reset busy/HI/LO got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    do_op("mult_neg", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC);
    do_op("multu_big", 3'b000, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC);
  endtask

  task automatic test_div();
    do_op("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    do_op("divu", 3'b010, 32'd7, 32'd2, 32'd1, 32'd3, DC);
  endtask

  task automatic test_div_boundary();
    do_op("divu_zero", 3'b010, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, DC);
    do_op("div_zero", 3'b011, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, DC);
    do_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] p;
    int          sa, sbv;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      p = {32'b0, a} * {32'b0, b};
      do_op("rand_multu", 3'b000, a, b, p[63:32], p[31:0], MC);
      p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
      do_op("rand_mult", 3'b001, a, b, p[63:32], p[31:0], MC);
      b = b >> (i * 8);
      if (b == 0) b = 32'd3;
      do_op("rand_divu", 3'b010, a, b, a % b, a / b, DC);
      if (b == 32'hFFFFFFFF) b = 32'd5;
      sa = signed'(a); sbv = signed'(b);
      if (i[0]) sbv = -sbv;
      do_op("rand_div", 3'b011, a, 32'(sbv), 32'(sa % sbv), 32'(sa / sbv), DC);
    end
  endtask

  task automatic test_busy_ignore();
    sb.push_back('{hi: 32'h0, lo: 32'd6, cyc: 32'(MC)});
    issue(3'b001, 32'd2, 32'd3);
    start = 1'b1; op = 3'b101; A = 32'hDEAD;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_ignore busy got=%b exp=1", busy); end
    op = 3'b010; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; A = 32'h0; B = 32'h0;
    run_check("busy_ignore", 2);
  endtask

  task automatic test_reset_abort();
    do_mt("mthi_pre", 3'b100, 32'h1111);
    do_mt("mtlo_pre", 3'b101, 32'h5555);
    issue(3'b001, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, HI, LO} !== '0) begin bad++; $display("FAIL reset_abort busy/HI/LO got=%b/%h/%h exp=0/0/0", busy, HI, LO); end
    @(negedge clk);
    reset_n = 1'b1;
    do_mt("mthi_cafe", 3'b100, 32'hCAFE);
    repeat (8) @(negedge clk);
    total++;
    if ({busy, HI, LO} !== {1'b0, 32'hCAFE, 32'h0}) begin
      bad++; $display("FAIL abort_no_write busy/HI/LO got=%b/%h/%h exp=0/0000cafe/0", busy, HI, LO);
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    do_mt("mthi0", 3'b100, 32'h0);
    do_mt("mtlo10", 3'b101, 32'd10);
    do_op("madd", 3'b110, 32'hFFFFFFFF, 32'd4, 32'h0, 32'd6, MC);
    do_op("msub", 3'b111, 32'd3, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, MC);
  endtask
`else
  task automatic test_noop();
    int hits;
    do_mt("mthi_n", 3'b100, 32'h11);
    do_mt("mtlo_n", 3'b101, 32'h22);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'b110 + 3'(k); A = 32'd5; B = 32'd6;
      @(negedge clk);
      start = 1'b0;
      hits = 0;
      repeat (MC + 1) begin
        if (busy !== 1'b0) hits++;
        @(negedge clk);
      end
      total++;
      if (hits != 0) begin bad++; $display("FAIL noop_busy got=%0d busy cycles exp=0", hits); end
      total++;
      if ({HI, LO} !== {32'h11, 32'h22}) begin bad++; $display("FAIL noop_hilo got=%h/%h exp=00000011/00000022", HI, LO); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_boundary();
    test_random();
    test_busy_ignore();
    test_reset_abort();
`ifdef MDU_MADD_EN
    test_madd();
`else
    test_noop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
